aes_key_expand_ctrl: RTL and testbench

AES_KEY_EXPAND_CTRL -- requirements
Module: aes_key_expand_ctrl

---
 rtl/aes_key_expand_ctrl_if.sv | 23 ++
 rtl/aes_key_expand_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_aes_key_expand_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expand_ctrl_if.sv
// Key-schedule bus: key handshake, round-key read port and status flags.
// The master side presents keys and round-key addresses; the slave side is
// the key expansion controller.
interface aes_key_expand_ctrl_if;
  logic         key_v_i;
  logic         key_ready_o;
  logic [255:0] key_i;
  logic         key_256_i;
  logic [3:0]   rk_addr_i;
  logic [127:0] rk_data_o;
  logic         busy_o;
  logic         done_o;

  modport master (
    output key_v_i, key_i, key_256_i, rk_addr_i,
    input  key_ready_o, rk_data_o, busy_o, done_o
  );

  modport slave (
    input  key_v_i, key_i, key_256_i, rk_addr_i,
    output key_ready_o, rk_data_o, busy_o, done_o
  );
endinterface

// File: rtl/aes_key_expand_ctrl.sv
// AES key expansion controller (FIPS-197 key schedule), one word per cycle.
// Optional feature macro: AES_KEY_EXPAND_256_EN enables AES-256 (Nk=8, Nr=14)
// with 60-word storage; without it only AES-128 is built (44 words) and
// key_256_i is ignored.

// Combinational AES S-box lookup; byte a sits at bits [(255-a)*8 +: 8].
module rom_sbox (
  input  logic [7:0] addr,
  output logic [7:0] data
);
  localparam logic [2047:0] SBOX = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };
  logic [10:0] bit_idx;
  assign bit_idx = {~addr, 3'b000};
  assign data    = SBOX[bit_idx +: 8];
endmodule

module aes_key_expand_ctrl (
  input logic                  clk_i,
  input logic                  reset_i,
  aes_key_expand_ctrl_if.slave bus
);
`ifdef AES_KEY_EXPAND_256_EN
  localparam int NW = 60;
`else
  localparam int NW = 44;
`endif

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t      state_reg;
  logic [5:0]  i_reg;
  logic [7:0]  rcon_reg;
  logic        is256_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        ready_reg;
  logic [31:0] w_mem [0:NW-1];

  logic        key_256_sel;
  logic        accept;
  logic [5:0]  nk;
  logic [5:0]  last_idx;
  logic [3:0]  nr;
  logic [5:0]  prev_idx;
  logic [5:0]  old_idx;
  logic [31:0] prev_word;
  logic [31:0] old_word;
  logic        mod0;
  logic        mod4_256;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] t_word;
  logic [31:0] w_new;
  logic [7:0]  rcon_next;

`ifdef AES_KEY_EXPAND_256_EN
  assign key_256_sel = bus.key_256_i;
`else
  assign key_256_sel = 1'b0;
`endif

  assign accept    = bus.key_v_i & ready_reg;
  assign nk        = is256_reg ? 6'd8 : 6'd4;
  assign last_idx  = is256_reg ? 6'd59 : 6'd43;
  assign nr        = is256_reg ? 4'd14 : 4'd10;
  assign rcon_next = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);

  // Source-word addresses; parked at 0 outside EXPAND so reads stay in range.
  always_comb begin
    prev_idx = 6'd0;
    old_idx  = 6'd0;
    if (state_reg == EXPAND) begin
      prev_idx = i_reg - 6'd1;
      old_idx  = i_reg - nk;
    end
  end

  assign prev_word = w_mem[prev_idx];
  assign old_word  = w_mem[old_idx];

  assign mod0 = is256_reg ? (i_reg[2:0] == 3'd0) : (i_reg[1:0] == 2'd0);
`ifdef AES_KEY_EXPAND_256_EN
  assign mod4_256 = is256_reg && (i_reg[2:0] == 3'd4);
`else
  assign mod4_256 = 1'b0;
`endif

  // RotWord only on the rcon words; the Nk=8 mid-block word is SubWord alone.
  assign sub_in = mod0 ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      rom_sbox u_sbox (
        .addr(sub_in[gi*8 +: 8]),
        .data(sub_out[gi*8 +: 8])
      );
    end
  endgenerate

  // Select the transformed temp word for the current schedule position.
  always_comb begin
    t_word = prev_word;
    if (mod0)          t_word = sub_out ^ {rcon_reg, 24'h0};
    else if (mod4_256) t_word = sub_out;
  end

  assign w_new = old_word ^ t_word;

  // Word storage: key load on handshake, one expanded word per EXPAND cycle.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int k = 0; k < 8; k++) begin
        if (k < 4 || key_256_sel) w_mem[k[5:0]] <= bus.key_i[(7-k)*32 +: 32];
      end
    end else if (state_reg == EXPAND) begin
      w_mem[i_reg] <= w_new;
    end
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
      i_reg     <= 6'd0;
      rcon_reg  <= 8'h01;
      is256_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            is256_reg <= key_256_sel;
            i_reg     <= key_256_sel ? 6'd8 : 6'd4;
            rcon_reg  <= 8'h01;
            state_reg <= EXPAND;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
            ready_reg <= 1'b0;
          end
        end
        EXPAND: begin
          i_reg <= i_reg + 6'd1;
          if (mod0) rcon_reg <= rcon_next;
          if (i_reg == last_idx) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            ready_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Round-key read port, masked to zero unless the schedule is complete.
  logic        addr_ok;
  logic [5:0]  rk_base;
  logic [31:0] rk_word [0:3];

  assign addr_ok = done_reg && (bus.rk_addr_i <= nr);
  assign rk_base = {bus.rk_addr_i, 2'b00};

  generate
    for (gi = 0; gi < 4; gi++) begin : g_rk
      logic [5:0] rd_idx;
      assign rd_idx      = addr_ok ? (rk_base + 6'(gi)) : 6'd0;
      assign rk_word[gi] = addr_ok ? w_mem[rd_idx] : 32'd0;
    end
  endgenerate

  assign bus.rk_data_o   = {rk_word[0], rk_word[1], rk_word[2], rk_word[3]};
  assign bus.key_ready_o = ready_reg;
  assign bus.busy_o      = busy_reg;
  assign bus.done_o      = done_reg;
endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Directed testbench for aes_key_expand_ctrl using FIPS-197 key vectors.
module tb_aes_key_expand_ctrl;
  logic clk_i;
  logic reset_i;
  int   checks;
  int   failures;

  aes_key_expand_ctrl_if bus ();

  aes_key_expand_ctrl dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  localparam logic [255:0] KEY_A = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                    128'hdeadbeef0badf00d5555aaaa12345678};
  localparam logic [255:0] KEY_B = {128'h000102030405060708090a0b0c0d0e0f,
                                    128'hffeeddccbbaa99887766554433221100};
  localparam logic [255:0] KEY_C = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  // Present one key for a single handshake edge (edge 0); returns at the negedge after it.
  task automatic start_key(input logic [255:0] key, input logic k256);
    @(negedge clk_i);
    bus.key_v_i   = 1'b1;
    bus.key_i     = key;
    bus.key_256_i = k256;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.key_v_i   = 1'b0;
  endtask

  // Step edges until done_o rises (bounded); tallies busy/ready/rk_data violations while busy.
  task automatic run_until_done(output int edges, output int busy_bad, output int rk_bad);
    edges = 0; busy_bad = 0; rk_bad = 0;
    bus.rk_addr_i = 4'd1;
    while (edges < 100) begin
      @(posedge clk_i);
      edges++;
      @(negedge clk_i);
      if (bus.done_o === 1'b1) break;
      if (bus.busy_o !== 1'b1 || bus.key_ready_o !== 1'b0) busy_bad++;
      #1;
      if (bus.rk_data_o !== 128'h0) rk_bad++;
    end
    bus.key_v_i = 1'b0;
  endtask

  task automatic read_rk(input logic [3:0] r, output logic [127:0] d);
    bus.rk_addr_i = r;
    #1;
    d = bus.rk_data_o;
  endtask

  task automatic test_reset;
    logic [127:0] d;
    reset_i = 1'b1;
    bus.key_v_i = 1'b0; bus.key_i = '0; bus.key_256_i = 1'b0; bus.rk_addr_i = 4'd0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    checks++; if (bus.key_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.key_ready_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
    read_rk(4'd0, d);
    checks++; if (d !== 128'h0) begin failures++; $display("FAIL reset_rk got=%h exp=0", d); end
    $display("reset: ready=%b busy=%b done=%b", bus.key_ready_o, bus.busy_o, bus.done_o);
  endtask

  task automatic test_aes128;
    int e, bb, rb;
    logic [127:0] d;
    start_key(KEY_A, 1'b0);
    checks++; if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0 || bus.key_ready_o !== 1'b0) begin
      failures++; $display("FAIL a128_edge0 got busy=%b done=%b ready=%b exp 1/0/0", bus.busy_o, bus.done_o, bus.key_ready_o); end
    run_until_done(e, bb, rb);
    $display("aes128 key=%h done after edge %0d", KEY_A[255:128], e);
    checks++; if (e !== 40) begin failures++; $display("FAIL a128_latency got=%0d exp=40", e); end
    checks++; if (bb !== 0) begin failures++; $display("FAIL a128_busy_window bad=%0d exp=0", bb); end
    checks++; if (rb !== 0) begin failures++; $display("FAIL a128_rk_masked_busy bad=%0d exp=0", rb); end
    checks++; if (bus.busy_o !== 1'b0 || bus.key_ready_o !== 1'b1) begin
      failures++; $display("FAIL a128_done_flags got busy=%b ready=%b exp 0/1", bus.busy_o, bus.key_ready_o); end
    read_rk(4'd0, d);
    checks++; if (d !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin failures++; $display("FAIL a128_r0 got=%h exp=2b7e151628aed2a6abf7158809cf4f3c", d); end
    read_rk(4'd1, d);
    checks++; if (d !== 128'ha0fafe1788542cb123a339392a6c7605) begin failures++; $display("FAIL a128_r1 got=%h exp=a0fafe1788542cb123a339392a6c7605", d); end
    read_rk(4'd2, d);
    checks++; if (d !== 128'hf2c295f27a96b9435935807a7359f67f) begin failures++; $display("FAIL a128_r2 got=%h exp=f2c295f27a96b9435935807a7359f67f", d); end
    read_rk(4'd10, d);
    checks++; if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin failures++; $display("FAIL a128_r10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", d); end
    read_rk(4'd11, d);
    checks++; if (d !== 128'h0) begin failures++; $display("FAIL a128_r11 got=%h exp=0", d); end
    read_rk(4'd15, d);
    checks++; if (d !== 128'h0) begin failures++; $display("FAIL a128_r15 got=%h exp=0", d); end
  endtask

  task automatic test_key256;
    int e, bb, rb;
    logic [127:0] d;
`ifdef AES_KEY_EXPAND_256_EN
    start_key(KEY_C, 1'b1);
    run_until_done(e, bb, rb);
    $display("aes256 key=%h done after edge %0d", KEY_C, e);
    checks++; if (e !== 52) begin failures++; $display("FAIL a256_latency got=%0d exp=52", e); end
    checks++; if (bb !== 0 || rb !== 0) begin failures++; $display("FAIL a256_busy_window busy_bad=%0d rk_bad=%0d exp 0/0", bb, rb); end
    read_rk(4'd0, d);
    checks++; if (d !== 128'h603deb1015ca71be2b73aef0857d7781) begin failures++; $display("FAIL a256_r0 got=%h exp=603deb1015ca71be2b73aef0857d7781", d); end
    read_rk(4'd1, d);
    checks++; if (d !== 128'h1f352c073b6108d72d9810a30914dff4) begin failures++; $display("FAIL a256_r1 got=%h exp=1f352c073b6108d72d9810a30914dff4", d); end
    read_rk(4'd14, d);
    checks++; if (d !== 128'hfe4890d1e6188d0b046df344706c631e) begin failures++; $display("FAIL a256_r14 got=%h exp=fe4890d1e6188d0b046df344706c631e", d); end
    read_rk(4'd15, d);
    checks++; if (d !== 128'h0) begin failures++; $display("FAIL a256_r15 got=%h exp=0", d); end
`else
    // Without the AES-256 option key_256_i is ignored: behaves as AES-128 on the upper half.
    start_key(KEY_A, 1'b1);
    run_until_done(e, bb, rb);
    $display("key_256_i ignored key=%h done after edge %0d", KEY_A[255:128], e);
    checks++; if (e !== 40) begin failures++; $display("FAIL k256_ignored_latency got=%0d exp=40", e); end
    read_rk(4'd10, d);
    checks++; if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin failures++; $display("FAIL k256_ignored_r10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", d); end
    read_rk(4'd14, d);
    checks++; if (d !== 128'h0) begin failures++; $display("FAIL k256_ignored_r14 got=%h exp=0", d); end
`endif
  endtask

  task automatic test_hold_key_v;
    int e, bb, rb;
    logic [127:0] d;
    @(negedge clk_i);
    bus.key_v_i = 1'b1; bus.key_i = KEY_A; bus.key_256_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.key_i = KEY_B;  // key_v_i stays high for the whole expansion
    checks++; if (bus.key_ready_o !== 1'b0) begin failures++; $display("FAIL hold_ready got=%b exp=0", bus.key_ready_o); end
    run_until_done(e, bb, rb);
    $display("hold key_v: done after edge %0d", e);
    checks++; if (e !== 40 || bb !== 0) begin failures++; $display("FAIL hold_latency got=%0d busy_bad=%0d exp 40/0", e, bb); end
    read_rk(4'd1, d);
    checks++; if (d !== 128'ha0fafe1788542cb123a339392a6c7605) begin failures++; $display("FAIL hold_r1 got=%h exp=a0fafe1788542cb123a339392a6c7605", d); end
    read_rk(4'd10, d);
    checks++; if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin failures++; $display("FAIL hold_r10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", d); end
  endtask

  task automatic test_reset_abort;
    int e, bb, rb;
    logic [127:0] d;
    start_key(KEY_B, 1'b0);
    repeat (19) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL abort_busy_pre got=%b exp=1", bus.busy_o); end
    reset_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    read_rk(4'd0, d);
    $display("reset at edge 20: done=%b busy=%b ready=%b", bus.done_o, bus.busy_o, bus.key_ready_o);
    checks++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.key_ready_o !== 1'b1) begin
      failures++; $display("FAIL abort_flags got done=%b busy=%b ready=%b exp 0/0/1", bus.done_o, bus.busy_o, bus.key_ready_o); end
    checks++; if (d !== 128'h0) begin failures++; $display("FAIL abort_rk got=%h exp=0", d); end
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      failures++; $display("FAIL abort_stays_idle got done=%b busy=%b exp 0/0", bus.done_o, bus.busy_o); end
    start_key(KEY_A, 1'b0);
    run_until_done(e, bb, rb);
    $display("after abort: new key done after edge %0d", e);
    checks++; if (e !== 40) begin failures++; $display("FAIL abort_new_latency got=%0d exp=40", e); end
    read_rk(4'd10, d);
    checks++; if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin failures++; $display("FAIL abort_new_r10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", d); end
  endtask

  task automatic test_back_to_back;
    int e, bb, rb;
    logic [127:0] d;
    // Entered in DONE holding the KEY_A schedule.
    checks++; if (bus.done_o !== 1'b1) begin failures++; $display("FAIL b2b_pre_done got=%b exp=1", bus.done_o); end
    start_key(KEY_B, 1'b0);
    checks++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      failures++; $display("FAIL b2b_drop got done=%b busy=%b exp 0/1", bus.done_o, bus.busy_o); end
    read_rk(4'd0, d);
    checks++; if (d !== 128'h0) begin failures++; $display("FAIL b2b_rk_masked got=%h exp=0", d); end
    run_until_done(e, bb, rb);
    $display("restart key=%h done after edge %0d", KEY_B[255:128], e);
    checks++; if (e !== 40 || bb !== 0 || rb !== 0) begin
      failures++; $display("FAIL b2b_latency got=%0d busy_bad=%0d rk_bad=%0d exp 40/0/0", e, bb, rb); end
    read_rk(4'd0, d);
    checks++; if (d !== 128'h000102030405060708090a0b0c0d0e0f) begin failures++; $display("FAIL b2b_r0 got=%h exp=000102030405060708090a0b0c0d0e0f", d); end
    read_rk(4'd1, d);
    checks++; if (d !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe) begin failures++; $display("FAIL b2b_r1 got=%h exp=d6aa74fdd2af72fadaa678f1d6ab76fe", d); end
    read_rk(4'd10, d);
    checks++; if (d !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin failures++; $display("FAIL b2b_r10 got=%h exp=13111d7fe3944a17f307a78b4d2b30c5", d); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_i = 1'b1;
    test_reset;
    test_aes128;
    test_key256;
    test_hold_key_v;
    test_reset_abort;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
